// File: rtl/dmem_arb_pkg.sv
// ---------------------------------------------------------------------------
// dmem_arb_pkg
// Shared definitions for the data-memory port arbiter of the dual-issue
// pipeline.
//   arb_state_t    : arbiter FSM states (IDLE, L1, L2, DONE)
//   RESULT_SRC_MEM : ResultSrc encoding that selects memory read data (a
//                    load); the control unit uses the same constant.
// ---------------------------------------------------------------------------
package dmem_arb_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    L1   = 2'd1,
    L2   = 2'd2,
    DONE = 2'd3
  } arb_state_t;

  localparam logic [1:0] RESULT_SRC_MEM = 2'b01;

endpackage

// File: rtl/sat_counter.sv
// ---------------------------------------------------------------------------
// sat_counter
// Up-counter that sticks at all-ones instead of wrapping.
// Ports:
//   clk   : clock
//   rst_n : asynchronous active-low reset, clears the count
//   inc   : increment request for this cycle
//   count : current count, WIDTH bits
// ---------------------------------------------------------------------------
module sat_counter #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             inc,
  output logic [WIDTH-1:0] count
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
    end else if (inc && (count != {WIDTH{1'b1}})) begin
      count <= count + 1'b1;
    end
  end

endmodule

// File: rtl/dmem_port_arbiter.sv
// ---------------------------------------------------------------------------
// dmem_port_arbiter
// Serialises the single data-memory port between the two lanes of a
// dual-issue bundle at the memory stage. Lane 1 (older) goes first. Upstream
// stages are stalled while accesses are outstanding. Load data is captured
// per lane, and the bundle is released to writeback once every access has
// been acknowledged.
// Ports:
//   clk, rst_n            : clock, asynchronous active-low reset
//   MemWriteMx            : lane x store request
//   ResultSrcMx           : lane x result source (RESULT_SRC_MEM means load)
//   AddressingControlMx   : lane x byte/half/word and sign control
//   ALUResultMx           : lane x address
//   WriteDataMx           : lane x store data
//   mem_req/we/addr/wdata/ctrl : memory port request, held until mem_ack
//   mem_ack, mem_rdata    : access complete, with read data in the same cycle
//   stall                 : holds the execute-to-memory and earlier registers
//   mw_en                 : memory-to-writeback enable (bundle retires)
//   ReadDataMx            : captured load data for lane x
//   conflict_cnt          : saturating count of bundles in which both lanes
//                           needed memory
// ---------------------------------------------------------------------------
module dmem_port_arbiter
  import dmem_arb_pkg::*;
#(
  parameter logic [1:0] RESULT_SRC_MEM = dmem_arb_pkg::RESULT_SRC_MEM,
  parameter int         CNT_W          = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             MemWriteM1,
  input  logic             MemWriteM2,
  input  logic [1:0]       ResultSrcM1,
  input  logic [1:0]       ResultSrcM2,
  input  logic [2:0]       AddressingControlM1,
  input  logic [2:0]       AddressingControlM2,
  input  logic [31:0]      ALUResultM1,
  input  logic [31:0]      ALUResultM2,
  input  logic [31:0]      WriteDataM1,
  input  logic [31:0]      WriteDataM2,
  output logic             mem_req,
  output logic             mem_we,
  output logic [31:0]      mem_addr,
  output logic [31:0]      mem_wdata,
  output logic [2:0]       mem_ctrl,
  input  logic             mem_ack,
  input  logic [31:0]      mem_rdata,
  output logic             stall,
  output logic             mw_en,
  output logic [31:0]      ReadDataM1,
  output logic [31:0]      ReadDataM2,
  output logic [CNT_W-1:0] conflict_cnt
);

  arb_state_t state, next_state;

  logic load1, load2;
  logic need1, need2;
  logic cnt_inc;

  assign load1 = (ResultSrcM1 == RESULT_SRC_MEM);
  assign load2 = (ResultSrcM2 == RESULT_SRC_MEM);
  assign need1 = MemWriteM1 | load1;
  assign need2 = MemWriteM2 | load2;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  // The request fields are only forwarded while a lane owns the port, so the
  // bus reads as all-zero whenever mem_req is low.
  always_comb begin
    next_state = state;
    mem_req    = 1'b0;
    mem_we     = 1'b0;
    mem_addr   = '0;
    mem_wdata  = '0;
    mem_ctrl   = '0;
    stall      = 1'b0;
    mw_en      = 1'b0;
    cnt_inc    = 1'b0;
    unique case (state)
      IDLE: begin
        if (need1 || need2) begin
          stall      = 1'b1;
          cnt_inc    = need1 && need2;
          next_state = need1 ? L1 : L2;
        end else begin
          mw_en = 1'b1;
        end
      end
      L1: begin
        mem_req   = 1'b1;
        mem_we    = MemWriteM1;
        mem_addr  = ALUResultM1;
        mem_wdata = WriteDataM1;
        mem_ctrl  = AddressingControlM1;
        stall     = 1'b1;
        if (mem_ack) begin
          next_state = need2 ? L2 : DONE;
        end
      end
      L2: begin
        mem_req   = 1'b1;
        mem_we    = MemWriteM2;
        mem_addr  = ALUResultM2;
        mem_wdata = WriteDataM2;
        mem_ctrl  = AddressingControlM2;
        stall     = 1'b1;
        if (mem_ack) begin
          next_state = DONE;
        end
      end
      DONE: begin
        mw_en      = 1'b1;
        next_state = IDLE;
      end
      default: begin
        next_state = IDLE;
      end
    endcase
  end

  // Only a load overwrites its lane's capture register. A store-only lane
  // and any ack outside L1/L2 leave the registers untouched.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ReadDataM1 <= '0;
      ReadDataM2 <= '0;
    end else begin
      if ((state == L1) && mem_ack && load1) begin
        ReadDataM1 <= mem_rdata;
      end
      if ((state == L2) && mem_ack && load2) begin
        ReadDataM2 <= mem_rdata;
      end
    end
  end

  sat_counter #(
    .WIDTH(CNT_W)
  ) u_conflict_cnt (
    .clk  (clk),
    .rst_n(rst_n),
    .inc  (cnt_inc),
    .count(conflict_cnt)
  );

endmodule

// File: tb/tb_dmem_port_arbiter.sv
// ---------------------------------------------------------------------------
// tb_dmem_port_arbiter
// Directed testbench for dmem_port_arbiter (CNT_W = 2 so that saturation is
// reachable). Inputs change just after the falling edge. Outputs are sampled
// 1 ns later, which is well away from the rising edge.
// ---------------------------------------------------------------------------
module tb_dmem_port_arbiter;

  logic        clk;
  logic        rst_n;
  logic        MemWriteM1, MemWriteM2;
  logic [1:0]  ResultSrcM1, ResultSrcM2;
  logic [2:0]  AddressingControlM1, AddressingControlM2;
  logic [31:0] ALUResultM1, ALUResultM2;
  logic [31:0] WriteDataM1, WriteDataM2;
  logic        mem_req, mem_we;
  logic [31:0] mem_addr, mem_wdata;
  logic [2:0]  mem_ctrl;
  logic        mem_ack;
  logic [31:0] mem_rdata;
  logic        stall, mw_en;
  logic [31:0] ReadDataM1, ReadDataM2;
  logic [1:0]  conflict_cnt;

  int checks = 0;
  int errors = 0;

  dmem_port_arbiter #(
    .RESULT_SRC_MEM(2'b01),
    .CNT_W         (2)
  ) dut (
    .clk                (clk),
    .rst_n              (rst_n),
    .MemWriteM1         (MemWriteM1),
    .MemWriteM2         (MemWriteM2),
    .ResultSrcM1        (ResultSrcM1),
    .ResultSrcM2        (ResultSrcM2),
    .AddressingControlM1(AddressingControlM1),
    .AddressingControlM2(AddressingControlM2),
    .ALUResultM1        (ALUResultM1),
    .ALUResultM2        (ALUResultM2),
    .WriteDataM1        (WriteDataM1),
    .WriteDataM2        (WriteDataM2),
    .mem_req            (mem_req),
    .mem_we             (mem_we),
    .mem_addr           (mem_addr),
    .mem_wdata          (mem_wdata),
    .mem_ctrl           (mem_ctrl),
    .mem_ack            (mem_ack),
    .mem_rdata          (mem_rdata),
    .stall              (stall),
    .mw_en              (mw_en),
    .ReadDataM1         (ReadDataM1),
    .ReadDataM2         (ReadDataM2),
    .conflict_cnt       (conflict_cnt)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Global time limit so a stuck run still ends with a report.
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation still running at %0t, required to finish earlier", $time);
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic next_cycle();
    @(negedge clk);
  endtask

  task automatic clear_bundle();
    MemWriteM1 = 0; MemWriteM2 = 0;
    ResultSrcM1 = 0; ResultSrcM2 = 0;
    AddressingControlM1 = 0; AddressingControlM2 = 0;
    ALUResultM1 = 0; ALUResultM2 = 0;
    WriteDataM1 = 0; WriteDataM2 = 0;
    mem_ack = 0; mem_rdata = 0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    clear_bundle();
    #3;
    checks++; if (mem_req !== 1'b0) begin errors++; $display("[TB] FAIL reset_mem_req: got %b expected 0", mem_req); end
    checks++; if (mem_we !== 1'b0) begin errors++; $display("[TB] FAIL reset_mem_we: got %b expected 0", mem_we); end
    checks++; if (stall !== 1'b0) begin errors++; $display("[TB] FAIL reset_stall: got %b expected 0", stall); end
    checks++; if (mw_en !== 1'b1) begin errors++; $display("[TB] FAIL reset_mw_en: got %b expected 1", mw_en); end
    checks++; if (ReadDataM1 !== 32'h0) begin errors++; $display("[TB] FAIL reset_rd1: got %h expected 0", ReadDataM1); end
    checks++; if (ReadDataM2 !== 32'h0) begin errors++; $display("[TB] FAIL reset_rd2: got %h expected 0", ReadDataM2); end
    checks++; if (conflict_cnt !== 2'd0) begin errors++; $display("[TB] FAIL reset_cnt: got %0d expected 0", conflict_cnt); end
    next_cycle();
    next_cycle();
    rst_n = 1'b1;
  endtask

  task automatic test_no_mem();
    for (int i = 0; i < 4; i++) begin
      next_cycle();
      clear_bundle();
      ALUResultM1 = 32'h40 + i;
      ALUResultM2 = 32'h80 + i;
      #1;
      checks++; if (stall !== 1'b0) begin errors++; $display("[TB] FAIL nomem_stall[%0d]: got %b expected 0", i, stall); end
      checks++; if (mw_en !== 1'b1) begin errors++; $display("[TB] FAIL nomem_mw_en[%0d]: got %b expected 1", i, mw_en); end
      checks++; if (mem_req !== 1'b0) begin errors++; $display("[TB] FAIL nomem_req[%0d]: got %b expected 0", i, mem_req); end
    end
  endtask

  task automatic test_lane2_load();
    // Cycle 1: IDLE sees the load and stalls.
    next_cycle();
    clear_bundle();
    ResultSrcM2 = 2'b01; ALUResultM2 = 32'h100; AddressingControlM2 = 3'b010;
    #1;
    checks++; if (stall !== 1'b1) begin errors++; $display("[TB] FAIL l2_c1_stall: got %b expected 1", stall); end
    checks++; if (mw_en !== 1'b0) begin errors++; $display("[TB] FAIL l2_c1_mw_en: got %b expected 0", mw_en); end
    checks++; if (mem_req !== 1'b0) begin errors++; $display("[TB] FAIL l2_c1_req: got %b expected 0", mem_req); end
    // Cycle 2: L2 with an immediate ack.
    next_cycle();
    mem_ack = 1'b1; mem_rdata = 32'hDEADBEEF;
    #1;
    checks++; if (mem_req !== 1'b1) begin errors++; $display("[TB] FAIL l2_c2_req: got %b expected 1", mem_req); end
    checks++; if (mem_addr !== 32'h100) begin errors++; $display("[TB] FAIL l2_c2_addr: got %h expected 00000100", mem_addr); end
    checks++; if (mem_we !== 1'b0) begin errors++; $display("[TB] FAIL l2_c2_we: got %b expected 0", mem_we); end
    checks++; if (mem_ctrl !== 3'b010) begin errors++; $display("[TB] FAIL l2_c2_ctrl: got %b expected 010", mem_ctrl); end
    checks++; if (stall !== 1'b1) begin errors++; $display("[TB] FAIL l2_c2_stall: got %b expected 1", stall); end
    // Cycle 3: DONE retires the bundle.
    next_cycle();
    mem_ack = 1'b0; mem_rdata = 32'h0;
    #1;
    checks++; if (mw_en !== 1'b1) begin errors++; $display("[TB] FAIL l2_c3_mw_en: got %b expected 1", mw_en); end
    checks++; if (stall !== 1'b0) begin errors++; $display("[TB] FAIL l2_c3_stall: got %b expected 0", stall); end
    checks++; if (mem_req !== 1'b0) begin errors++; $display("[TB] FAIL l2_c3_req: got %b expected 0", mem_req); end
    checks++; if (mem_addr !== 32'h0) begin errors++; $display("[TB] FAIL l2_c3_addr_idle: got %h expected 0", mem_addr); end
    checks++; if (ReadDataM2 !== 32'hDEADBEEF) begin errors++; $display("[TB] FAIL l2_c3_rd2: got %h expected deadbeef", ReadDataM2); end
    checks++; if (conflict_cnt !== 2'd0) begin errors++; $display("[TB] FAIL l2_cnt: got %0d expected 0", conflict_cnt); end
    next_cycle();
    clear_bundle();
  endtask

  task automatic test_store_load();
    // Expected per cycle 1..8: req, we, addr, wdata, stall, mw_en; ack driven.
    logic        exp_req   [1:8];
    logic        exp_we    [1:8];
    logic [31:0] exp_addr  [1:8];
    logic [31:0] exp_wdata [1:8];
    logic        exp_stall [1:8];
    logic        ack_in    [1:8];
    logic [31:0] rdata_in  [1:8];
    exp_req   = '{0, 1, 1, 1, 1, 1, 1, 0};
    exp_we    = '{0, 1, 1, 1, 0, 0, 0, 0};
    exp_addr  = '{0, 32'h200, 32'h200, 32'h200, 32'h204, 32'h204, 32'h204, 0};
    exp_wdata = '{0, 32'h55, 32'h55, 32'h55, 32'h77, 32'h77, 32'h77, 0};
    exp_stall = '{1, 1, 1, 1, 1, 1, 1, 0};
    ack_in    = '{0, 0, 0, 1, 0, 0, 1, 0};
    rdata_in  = '{0, 0, 0, 32'hBAD0BAD0, 0, 0, 32'h12345678, 0};
    next_cycle();
    clear_bundle();
    MemWriteM1 = 1'b1; ALUResultM1 = 32'h200; WriteDataM1 = 32'h55; AddressingControlM1 = 3'b010;
    ResultSrcM2 = 2'b01; ALUResultM2 = 32'h204; WriteDataM2 = 32'h77; AddressingControlM2 = 3'b100;
    for (int c = 1; c <= 8; c++) begin
      if (c > 1) next_cycle();
      mem_ack = ack_in[c]; mem_rdata = rdata_in[c];
      #1;
      checks++; if (mem_req !== exp_req[c]) begin errors++; $display("[TB] FAIL sl_req[c%0d]: got %b expected %b", c, mem_req, exp_req[c]); end
      checks++; if (mem_we !== exp_we[c]) begin errors++; $display("[TB] FAIL sl_we[c%0d]: got %b expected %b", c, mem_we, exp_we[c]); end
      checks++; if (mem_addr !== exp_addr[c]) begin errors++; $display("[TB] FAIL sl_addr[c%0d]: got %h expected %h", c, mem_addr, exp_addr[c]); end
      checks++; if (mem_wdata !== exp_wdata[c]) begin errors++; $display("[TB] FAIL sl_wdata[c%0d]: got %h expected %h", c, mem_wdata, exp_wdata[c]); end
      checks++; if (stall !== exp_stall[c]) begin errors++; $display("[TB] FAIL sl_stall[c%0d]: got %b expected %b", c, stall, exp_stall[c]); end
      checks++; if (mw_en !== (c == 8)) begin errors++; $display("[TB] FAIL sl_mw_en[c%0d]: got %b expected %b", c, mw_en, (c == 8)); end
    end
    checks++; if (ReadDataM2 !== 32'h12345678) begin errors++; $display("[TB] FAIL sl_rd2: got %h expected 12345678", ReadDataM2); end
    checks++; if (ReadDataM1 !== 32'h0) begin errors++; $display("[TB] FAIL sl_rd1_store_only: got %h expected 0", ReadDataM1); end
    checks++; if (conflict_cnt !== 2'd1) begin errors++; $display("[TB] FAIL sl_cnt: got %0d expected 1", conflict_cnt); end
    next_cycle();
    clear_bundle();
  endtask

  task automatic test_back_to_back();
    // The count starts at 1 and saturates at 3 with CNT_W = 2.
    logic [1:0] exp_cnt [0:2];
    exp_cnt = '{2'd2, 2'd3, 2'd3};
    for (int b = 0; b < 3; b++) begin
      next_cycle();
      clear_bundle();
      ResultSrcM1 = 2'b01; ALUResultM1 = 32'h300 + 32'(b * 8);
      ResultSrcM2 = 2'b01; ALUResultM2 = 32'h304 + 32'(b * 8);
      next_cycle();
      mem_ack = 1'b1; mem_rdata = 32'hA000_0000 + 32'(b);
      next_cycle();
      mem_ack = 1'b1; mem_rdata = 32'hB000_0000 + 32'(b);
      next_cycle();
      mem_ack = 1'b0; mem_rdata = 32'h0;
      #1;
      checks++; if (mw_en !== 1'b1) begin errors++; $display("[TB] FAIL b2b_mw_en[%0d]: got %b expected 1", b, mw_en); end
      checks++; if (ReadDataM1 !== 32'hA000_0000 + 32'(b)) begin errors++; $display("[TB] FAIL b2b_rd1[%0d]: got %h expected %h", b, ReadDataM1, 32'hA000_0000 + 32'(b)); end
      checks++; if (ReadDataM2 !== 32'hB000_0000 + 32'(b)) begin errors++; $display("[TB] FAIL b2b_rd2[%0d]: got %h expected %h", b, ReadDataM2, 32'hB000_0000 + 32'(b)); end
      checks++; if (conflict_cnt !== exp_cnt[b]) begin errors++; $display("[TB] FAIL b2b_cnt[%0d]: got %0d expected %0d", b, conflict_cnt, exp_cnt[b]); end
    end
    next_cycle();
    clear_bundle();
  endtask

  task automatic test_spurious_ack();
    // Registers currently hold A0000002 / B0000002 from the previous test.
    next_cycle();
    mem_ack = 1'b1; mem_rdata = 32'h1111_1111;
    #1;
    checks++; if (mem_req !== 1'b0) begin errors++; $display("[TB] FAIL sp_idle_req: got %b expected 0", mem_req); end
    next_cycle();
    mem_ack = 1'b0;
    #1;
    checks++; if (mw_en !== 1'b1 || mem_req !== 1'b0) begin errors++; $display("[TB] FAIL sp_idle_state: got mw_en=%b req=%b expected mw_en=1 req=0", mw_en, mem_req); end
    checks++; if (ReadDataM1 !== 32'hA000_0002) begin errors++; $display("[TB] FAIL sp_idle_rd1: got %h expected a0000002", ReadDataM1); end
    // Lane-1 load bundle, then an ack pulse during DONE.
    next_cycle();
    ResultSrcM1 = 2'b01; ALUResultM1 = 32'h400;
    next_cycle();
    mem_ack = 1'b1; mem_rdata = 32'hCAFEF00D;
    next_cycle();
    mem_ack = 1'b1; mem_rdata = 32'h2222_2222;
    #1;
    checks++; if (mw_en !== 1'b1) begin errors++; $display("[TB] FAIL sp_done_mw_en: got %b expected 1", mw_en); end
    next_cycle();
    clear_bundle();
    #1;
    checks++; if (mem_req !== 1'b0 || mw_en !== 1'b1) begin errors++; $display("[TB] FAIL sp_done_next_idle: got req=%b mw_en=%b expected req=0 mw_en=1", mem_req, mw_en); end
    checks++; if (ReadDataM1 !== 32'hCAFEF00D) begin errors++; $display("[TB] FAIL sp_done_rd1: got %h expected cafef00d", ReadDataM1); end
    checks++; if (ReadDataM2 !== 32'hB000_0002) begin errors++; $display("[TB] FAIL sp_done_rd2: got %h expected b0000002", ReadDataM2); end
  endtask

  task automatic test_reset_mid();
    next_cycle();
    clear_bundle();
    ResultSrcM1 = 2'b01; ALUResultM1 = 32'h500;
    ResultSrcM2 = 2'b01; ALUResultM2 = 32'h504;
    next_cycle();
    mem_ack = 1'b1; mem_rdata = 32'h3333_3333;
    next_cycle();
    mem_ack = 1'b0;
    #1;
    checks++; if (mem_req !== 1'b1 || mem_addr !== 32'h504) begin errors++; $display("[TB] FAIL rm_l2_wait: got req=%b addr=%h expected req=1 addr=00000504", mem_req, mem_addr); end
    // Reset arrives mid-cycle with a pipeline flush of the bundle inputs.
    #1;
    rst_n = 1'b0;
    clear_bundle();
    #1;
    checks++; if (mem_req !== 1'b0) begin errors++; $display("[TB] FAIL rm_req: got %b expected 0", mem_req); end
    checks++; if (stall !== 1'b0) begin errors++; $display("[TB] FAIL rm_stall: got %b expected 0", stall); end
    checks++; if (mw_en !== 1'b1) begin errors++; $display("[TB] FAIL rm_mw_en: got %b expected 1", mw_en); end
    checks++; if (conflict_cnt !== 2'd0) begin errors++; $display("[TB] FAIL rm_cnt: got %0d expected 0", conflict_cnt); end
    checks++; if (ReadDataM1 !== 32'h0) begin errors++; $display("[TB] FAIL rm_rd1: got %h expected 0", ReadDataM1); end
    next_cycle();
    rst_n = 1'b1;
    next_cycle();
    #1;
    checks++; if (mem_req !== 1'b0 || mw_en !== 1'b1) begin errors++; $display("[TB] FAIL rm_after: got req=%b mw_en=%b expected req=0 mw_en=1", mem_req, mw_en); end
  endtask

  initial begin
    $display("[TB] starting dmem_port_arbiter tests");
    test_reset();
    test_no_mem();
    test_lane2_load();
    test_store_load();
    test_back_to_back();
    test_spurious_ack();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/dmem_port_arbiter.md
# dmem_port_arbiter

Sequences the single data-memory port between the two issue lanes of the dual-issue pipeline. It sits at the memory stage, after the execute-to-memory register. When one or both lanes of the current bundle need memory, it serialises the accesses with lane 1 (older) first. It stalls the upstream stages while it works, captures load data per lane, and releases the bundle to writeback only once every access has been acknowledged.

## Interface
Parameters:
- `RESULT_SRC_MEM`, default 2'b01: `ResultSrc` encoding that selects memory read data, i.e. a load.
- `CNT_W`, default 16: width of the dual-conflict counter.

Ports:
- `clk`, in, 1: clock. All state updates on the rising edge.
- `rst_n`, in, 1: asynchronous, active-low reset.
- `MemWriteM1` / `MemWriteM2`, in, 1: lane store request.
- `ResultSrcM1` / `ResultSrcM2`, in, 2: lane result source. Equal to `RESULT_SRC_MEM` means load.
- `AddressingControlM1` / `AddressingControlM2`, in, 3: byte/half/word and sign control.
- `ALUResultM1` / `ALUResultM2`, in, 32: lane address.
- `WriteDataM1` / `WriteDataM2`, in, 32: lane store data.
- `mem_req`, out, 1: port request. Held until acknowledged.
- `mem_we`, out, 1: request is a store.
- `mem_addr`, out, 32: request address.
- `mem_wdata`, out, 32: request store data.
- `mem_ctrl`, out, 3: request addressing control.
- `mem_ack`, in, 1: access complete. Read data is valid in the same cycle.
- `mem_rdata`, in, 32: read data.
- `stall`, out, 1: drives en1/en2 low on the execute-to-memory register and on all earlier pipeline registers.
- `mw_en`, out, 1: memory-to-writeback register enable. High only when the bundle may retire.
- `ReadDataM1` / `ReadDataM2`, out, 32: captured load data, valid while `mw_en` is high.
- `conflict_cnt`, out, `CNT_W`: saturating count of bundles in which both lanes needed memory.

## Operation
- Lane need: `need_i = MemWriteMi | (ResultSrcMi == RESULT_SRC_MEM)`.
- FSM states and transitions:
  - IDLE, with no lane needing memory: `stall=0`, `mw_en=1`, stay in IDLE.
  - IDLE, with a need: `stall=1`, `mw_en=0`. Go to L1 if `need1`, otherwise L2. Increment `conflict_cnt` (saturating at all-ones) if both lanes need memory.
  - L1: `mem_req=1`; `mem_we`, `mem_addr`, `mem_wdata`, `mem_ctrl` come from lane 1; `stall=1`. On `mem_ack`, capture `mem_rdata` into the lane-1 register if lane 1 is a load. Then go to L2 if `need2`, otherwise DONE.
  - L2: same as L1 but for lane 2; on `mem_ack`, go to DONE.
  - DONE: `stall=0`, `mw_en=1`, next state IDLE.
- `mem_req`/`mem_we` are decoded from the state. When `mem_req=0`, `mem_addr`, `mem_wdata` and `mem_ctrl` are driven to 0.
- Capture registers hold their value until overwritten. A lane with no load shows a stale value, which the writeback mux ignores.
- A store-only lane does not update its capture register.
- `mem_ack` while `mem_req=0` is ignored.

## Timing
- Reset (async assert, sync-safe release):
  - state = IDLE.
  - Capture registers = 0.
  - `conflict_cnt` = 0.
  - Outputs: `mem_req=0`, `mem_we=0`, `stall=0`. `mw_en` follows IDLE decode, so it is 1 with no need.
  - Reset mid-access drops `mem_req` immediately; the access is abandoned.
- `mem_ack` may arrive in the first cycle of L1/L2. The minimum path is then:
  - No memory op: 1 cycle per bundle.
  - One memory op: 3 cycles (IDLE, L1/L2, DONE).
  - Two memory ops: 4 cycles.
- Each wait cycle without `mem_ack` adds exactly one cycle.
- Request fields are stable from the first cycle of L1/L2 until the `mem_ack` cycle. Bundle inputs are held stable by `stall`.
- `stall` and `mw_en` are never both 1.

## Structure
- Shared package `dmem_arb_pkg`:
  - `arb_state_t` enum: IDLE, L1, L2, DONE.
  - `RESULT_SRC_MEM` constant, shared with the control unit.
- One sub-module, `sat_counter`, parameterised on width with increment input and saturation.

## Test plan
- No memory ops: `ResultSrcM1=ResultSrcM2=0`, `MemWrite=0` -> `stall=0`, `mw_en=1` every cycle, `mem_req` never asserted.
- Lane-2 load only, addr 0x100, ack in first cycle, `mem_rdata=0xDEADBEEF` -> `stall` high 2 cycles, one request with `mem_addr=0x100`, `mem_we=0`; `mw_en` in cycle 3 with `ReadDataM2=0xDEADBEEF`.
- Lane-1 store (0x200, data 0x55) plus lane-2 load (0x204), ack delayed 2 cycles each -> store issued first with `mem_we=1`, then load; bundle retires in cycle 8; `conflict_cnt` increments to 1.
- Back-to-back dual-memory bundles with `CNT_W=2` -> `conflict_cnt` saturates at 3.
- Assert `rst_n=0` during L2 wait -> `mem_req` drops asynchronously, state IDLE, `conflict_cnt=0`, `stall=0`.
- `mem_ack` pulsed in IDLE and DONE -> no state change, capture registers unchanged.
